// File: rtl/mac_issue_stage.sv
// mac_issue_stage: 3-stage signed 16x16 multiply-accumulate issue stage with
// read-after-write forwarding, downstream stall and overflow/op-count status.
module mac_issue_stage #(
   parameter int DATA_W   = 16,
   parameter int ACC_W    = 32,
   parameter int IDX_W    = 5,
   parameter bit SATURATE = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_op,
   input  logic [IDX_W-1:0]  in_idx,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              stall,
   output logic [IDX_W-1:0]  acc_raddr,
   input  logic [ACC_W-1:0]  acc_rdata,
   output logic              acc_we,
   output logic [IDX_W-1:0]  acc_waddr,
   output logic [ACC_W-1:0]  acc_wdata,
   output logic              busy,
   input  logic              ovf_clear,
   output logic              ovf_sticky,
   output logic [15:0]       op_count
);
   logic                     s1_v, s2_v;
   logic [1:0]               s1_op, s2_op;
   logic [IDX_W-1:0]         s1_idx, s2_idx;
   logic signed [DATA_W-1:0] s1_a, s1_b;
   logic signed [ACC_W-1:0]  prod;
   logic [ACC_W-1:0]         s2_p, s2_old, old;
   logic [ACC_W:0]           r;
   logic                     ovf;
   assign in_ready  = !stall;
   assign busy      = s1_v || s2_v;
   assign acc_raddr = s1_idx;
   assign acc_waddr = s2_idx;
   assign acc_we    = s2_v && !stall && !reset;
   assign prod      = ACC_W'(s1_a) * ACC_W'(s1_b);
   // A write still sitting in S2 to the same accumulator is newer than the bank.
   assign old       = (s2_v && s2_idx == s1_idx) ? acc_wdata : acc_rdata;
   always_comb begin
      r = s2_op == 2'b00 ? {s2_p[ACC_W-1], s2_p} :
          s2_op == 2'b01 ? {s2_old[ACC_W-1], s2_old} + {s2_p[ACC_W-1], s2_p} :
          s2_op == 2'b10 ? {s2_old[ACC_W-1], s2_old} - {s2_p[ACC_W-1], s2_p} : '0;
      ovf = r[ACC_W] != r[ACC_W-1];
      acc_wdata = (ovf && SATURATE) ? (r[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                                    : r[ACC_W-1:0];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_v       <= 1'b0;
         s1_op      <= '0;
         s1_idx     <= '0;
         s1_a       <= '0;
         s1_b       <= '0;
         s2_v       <= 1'b0;
         s2_op      <= '0;
         s2_idx     <= '0;
         s2_p       <= '0;
         s2_old     <= '0;
         ovf_sticky <= 1'b0;
         op_count   <= '0;
      end else begin
         if (!stall) begin
            s1_v <= in_valid;
            if (in_valid) begin
               s1_op  <= in_op;
               s1_idx <= in_idx;
               s1_a   <= in_a;
               s1_b   <= in_b;
            end
            s2_v   <= s1_v;
            s2_op  <= s1_op;
            s2_idx <= s1_idx;
            s2_p   <= prod;
            s2_old <= old;
         end
         if (acc_we && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
         ovf_sticky <= (acc_we && ovf) || (ovf_sticky && !ovf_clear);
      end
   end
endmodule

// File: tb/tb_mac_issue_stage.sv
// tb_mac_issue_stage: directed checks of mac_issue_stage with a behavioural
// accumulator bank; a second instance runs in wrap (SATURATE=0) mode.
module tb_mac_issue_stage;
   logic        clk = 1'b0, reset = 1'b1;
   logic        in_valid = 1'b0, stall = 1'b0, ovf_clear = 1'b0;
   logic [1:0]  in_op = 2'b00;
   logic [4:0]  in_idx = '0;
   logic [15:0] in_a = '0, in_b = '0;
   logic        in_ready, acc_we, busy, ovf_sticky;
   logic [4:0]  acc_raddr, acc_waddr;
   logic [31:0] acc_rdata, acc_wdata;
   logic [15:0] op_count;
   logic        w_in_ready, w_acc_we, w_busy, w_ovf_sticky;
   logic [4:0]  w_acc_raddr, w_acc_waddr;
   logic [31:0] w_acc_rdata, w_acc_wdata;
   logic [15:0] w_op_count;
   logic [31:0] bank [32] = '{default: 32'h0};
   logic        pre_we = 1'b0;
   logic [4:0]  pre_idx = '0;
   logic [31:0] pre_val = '0;
   int          total = 0, passed = 0;

   always #5 clk = ~clk;

   mac_issue_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_idx(in_idx), .in_a(in_a), .in_b(in_b), .stall(stall),
      .acc_raddr(acc_raddr), .acc_rdata(acc_rdata), .acc_we(acc_we),
      .acc_waddr(acc_waddr), .acc_wdata(acc_wdata), .busy(busy),
      .ovf_clear(ovf_clear), .ovf_sticky(ovf_sticky), .op_count(op_count));

   mac_issue_stage #(.SATURATE(1'b0)) dut_wrap (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
      .in_op(in_op), .in_idx(in_idx), .in_a(in_a), .in_b(in_b), .stall(stall),
      .acc_raddr(w_acc_raddr), .acc_rdata(w_acc_rdata), .acc_we(w_acc_we),
      .acc_waddr(w_acc_waddr), .acc_wdata(w_acc_wdata), .busy(w_busy),
      .ovf_clear(ovf_clear), .ovf_sticky(w_ovf_sticky), .op_count(w_op_count));

   assign acc_rdata   = bank[acc_raddr];
   assign w_acc_rdata = bank[w_acc_raddr];

   always @(posedge clk) begin
      if (pre_we) bank[pre_idx] <= pre_val;
      else if (acc_we) bank[acc_waddr] <= acc_wdata;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   task automatic preset(input logic [4:0] i, input logic [31:0] v);
      pre_we = 1'b1; pre_idx = i; pre_val = v;
      tick;
      pre_we = 1'b0;
   endtask

   task automatic issue(input logic [1:0] op, input logic [4:0] i, input logic [15:0] a, input logic [15:0] b);
      in_valid = 1'b1; in_op = op; in_idx = i; in_a = a; in_b = b;
   endtask

   initial begin
      tick;
      tick;
      reset = 1'b0;
      chk("rst_we", acc_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_raddr", acc_raddr, 0);
      chk("rst_waddr", acc_waddr, 0);
      chk("rst_wdata", acc_wdata, 0);
      chk("rst_cnt", op_count, 0);
      chk("rst_ovf", ovf_sticky, 0);
      // single MAC: latency
      preset(5'd8, 32'h0);
      issue(2'b01, 5'd8, 16'd1, 16'd1);
      tick;
      in_valid = 1'b0;
      chk("mac_busy", busy, 1);
      chk("mac_raddr", acc_raddr, 8);
      chk("mac_we_early", acc_we, 0);
      tick;
      chk("mac_we", acc_we, 1);
      chk("mac_waddr", acc_waddr, 8);
      chk("mac_wdata", acc_wdata, 32'h1);
      tick;
      chk("mac_cnt", op_count, 1);
      chk("mac_we_done", acc_we, 0);
      chk("mac_bank", bank[8], 32'h1);
      // forwarding with a stale bank entry
      preset(5'd9, 32'h5555_5555);
      issue(2'b00, 5'd9, 16'd3, 16'd1);
      tick;
      issue(2'b01, 5'd9, 16'd2, 16'd5);
      tick;
      in_valid = 1'b0;
      chk("fwd_w1", acc_wdata, 32'h3);
      chk("fwd_we1", acc_we, 1);
      tick;
      chk("fwd_w2", acc_wdata, 32'hD);
      chk("fwd_we2", acc_we, 1);
      tick;
      chk("fwd_cnt", op_count, 3);
      chk("fwd_bank", bank[9], 32'hD);
      // positive overflow, saturating and wrapping instances
      preset(5'd10, 32'h7FFF_FFF0);
      issue(2'b01, 5'd10, 16'd16, 16'd1);
      tick;
      in_valid = 1'b0;
      tick;
      chk("sat_wdata", acc_wdata, 32'h7FFF_FFFF);
      chk("wrap_wdata", w_acc_wdata, 32'h8000_0000);
      chk("ovf_pre", ovf_sticky, 0);
      tick;
      chk("sat_ovf", ovf_sticky, 1);
      chk("wrap_ovf", w_ovf_sticky, 1);
      ovf_clear = 1'b1;
      tick;
      ovf_clear = 1'b0;
      chk("clr_ovf", ovf_sticky, 0);
      chk("clr_wovf", w_ovf_sticky, 0);
      // MSU with most-negative operands, then CLR
      preset(5'd11, 32'h0);
      issue(2'b10, 5'd11, 16'h8000, 16'h8000);
      tick;
      issue(2'b11, 5'd11, 16'd7, 16'd7);
      tick;
      in_valid = 1'b0;
      chk("msu_wdata", acc_wdata, 32'hC000_0000);
      tick;
      chk("clr_wdata", acc_wdata, 32'h0);
      chk("clr_we", acc_we, 1);
      tick;
      chk("clr_bank", bank[11], 32'h0);
      chk("msu_ovf", ovf_sticky, 0);
      chk("msu_cnt", op_count, 6);
      // stall mid-stream
      preset(5'd1, 32'hDEAD_BEEF);
      preset(5'd2, 32'd100);
      issue(2'b00, 5'd1, 16'd2, 16'd3);
      tick;
      issue(2'b01, 5'd1, 16'd1, 16'd4);
      tick;
      issue(2'b01, 5'd2, 16'hFFFF, 16'd5);
      stall = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("stl_ready", in_ready, 0);
         chk("stl_we", acc_we, 0);
         chk("stl_cnt", op_count, 6);
         tick;
      end
      stall = 1'b0;
      #1;
      chk("rel_we1", acc_we, 1);
      chk("rel_a1", acc_waddr, 1);
      chk("rel_w1", acc_wdata, 32'd6);
      tick;
      in_valid = 1'b0;
      chk("rel_a2", acc_waddr, 1);
      chk("rel_w2", acc_wdata, 32'd10);
      tick;
      chk("rel_a3", acc_waddr, 2);
      chk("rel_w3", acc_wdata, 32'd95);
      tick;
      chk("rel_we_done", acc_we, 0);
      chk("rel_cnt", op_count, 9);
      chk("rel_bank1", bank[1], 32'd10);
      chk("rel_bank2", bank[2], 32'd95);
      // reset with two ops in flight
      preset(5'd3, 32'h77);
      preset(5'd4, 32'h88);
      preset(5'd5, 32'h1);
      issue(2'b01, 5'd3, 16'd1, 16'd1);
      tick;
      issue(2'b01, 5'd4, 16'd1, 16'd1);
      tick;
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("rr_we_in", acc_we, 0);
      tick;
      reset = 1'b0;
      chk("rr_busy", busy, 0);
      chk("rr_we", acc_we, 0);
      chk("rr_cnt", op_count, 0);
      tick;
      chk("rr_we2", acc_we, 0);
      chk("rr_bank3", bank[3], 32'h77);
      chk("rr_bank4", bank[4], 32'h88);
      issue(2'b01, 5'd5, 16'd2, 16'd2);
      tick;
      in_valid = 1'b0;
      tick;
      chk("rr_new_a", acc_waddr, 5);
      chk("rr_new_w", acc_wdata, 32'd5);
      tick;
      chk("rr_new_cnt", op_count, 1);
      chk("rr_new_bank", bank[5], 32'd5);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
